// File: rtl/multicycle_core.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB core with one shared ALU, an internal register file and data memory.
// Define MULTICYCLE_CORE_BRANCH_EN to execute opcode 8 as BEQ; otherwise opcode 8 is a NOP.
module multicycle_core #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 6,
   parameter int REG_COUNT  = 16,
   parameter int DMEM_DEPTH = 128
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic [DATA_W-1:0] seg_display,
   output logic              retire,
   output logic              halted
);

   localparam int         DA_W    = $clog2(DMEM_DEPTH);
   localparam logic [4:0] REG_LIM = 5'(REG_COUNT);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LW   = 4'd6;
   localparam logic [3:0] OP_SW   = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_HALT = 4'd9;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t                   state;
   logic [ADDR_W-1:0]        pc;
   logic [DATA_W-1:0]        regs [16];
   logic [DATA_W-1:0]        dmem [DMEM_DEPTH];

   logic [31:0]              ir_p0;
   logic signed [DATA_W-1:0] a_p1, b_p1;
   logic signed [DATA_W-1:0] alu_p2;
   logic signed [DATA_W-1:0] mdr_p3;

   logic [3:0]               op, rd, rs, rt;
   logic signed [15:0]       imm16;
   logic signed [DATA_W-1:0] imm_sx;
   logic [DA_W-1:0]          daddr;
   logic [DATA_W-1:0]        wb_val;

   assign op        = ir_p0[31:28];
   assign rd        = ir_p0[27:24];
   assign rs        = ir_p0[23:20];
   assign rt        = ir_p0[19:16];
   assign imm16     = ir_p0[15:0];
   assign imm_sx    = DATA_W'(imm16);
   assign daddr     = alu_p2[DA_W-1:0];
   assign wb_val    = (op == OP_LW) ? mdr_p3 : alu_p2;
   assign imem_addr = pc;

   // Unimplemented register indices behave as a hard-wired zero.
   function automatic logic signed [DATA_W-1:0] reg_read(input logic [3:0] idx);
      return ({1'b0, idx} < REG_LIM) ? regs[idx] : '0;
   endfunction

   function automatic logic signed [DATA_W-1:0] alu(
      input logic [3:0]               f,
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b,
      input logic signed [DATA_W-1:0] imm
   );
      case (f)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return a + imm;
      endcase
   endfunction

`ifdef MULTICYCLE_CORE_BRANCH_EN
   logic take_br;
   assign take_br = (op == OP_BEQ) && (a_p1 == b_p1);
`endif

   // FETCH -> IR
   always_ff @(posedge clk) begin
      case (state)
         S_FETCH:  ir_p0 <= imem_data;
         // DECODE -> A/B
         S_DECODE: begin
            a_p1 <= reg_read(rs);
            b_p1 <= reg_read(rt);
         end
         // EXEC -> ALUOut
         S_EXEC:   alu_p2 <= alu(op, a_p1, b_p1, imm_sx);
         // MEM -> MDR
         S_MEM:    mdr_p3 <= dmem[daddr];
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_FETCH;
         pc          <= '0;
         seg_display <= '0;
         retire      <= 1'b0;
         halted      <= 1'b0;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (state)
            S_FETCH: begin
               pc    <= pc + ADDR_W'(1);
               state <= S_DECODE;
            end
            S_DECODE: begin
               state  <= S_EXEC;
               // BEQ, HALT and the NOP opcodes all finish in EXEC.
               retire <= (op >= OP_BEQ);
            end
            S_EXEC: begin
               if (op <= OP_ADDI) begin
                  state  <= S_WB;
                  retire <= 1'b1;
               end else if (op == OP_LW) begin
                  state <= S_MEM;
               end else if (op == OP_SW) begin
                  state  <= S_MEM;
                  retire <= 1'b1;
               end else if (op == OP_HALT) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end else begin
                  state <= S_FETCH;
`ifdef MULTICYCLE_CORE_BRANCH_EN
                  if (take_br) pc <= pc + imm_sx[ADDR_W-1:0];
`endif
               end
            end
            S_MEM: begin
               if (op == OP_SW) begin
                  dmem[daddr] <= b_p1;
                  state       <= S_FETCH;
               end else begin
                  state  <= S_WB;
                  retire <= 1'b1;
               end
            end
            S_WB: begin
               seg_display <= wb_val;
               if (rd != 4'd0 && {1'b0, rd} < REG_LIM) regs[rd] <= wb_val;
               state <= S_FETCH;
            end
            S_HALT:  ;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed-program bench for multicycle_core: a default-sized core and a REG_COUNT=4 core run the same programs.
module tb_multicycle_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  imem_addr, imem_addr4;
   logic [31:0] imem_data, imem_data4;
   logic [31:0] seg_display, seg4;
   logic        retire, retire4, halted, halted4;

   logic [31:0] prog [64];
   int          n_vec = 0;
   int          n_err = 0;
   int          rc[$];
   logic [31:0] sq[$];
   logic [31:0] sq4[$];

   localparam logic [31:0] HALT_I = 32'h9000_0000;

   always #5 clk = ~clk;

   assign imem_data  = prog[imem_addr];
   assign imem_data4 = prog[imem_addr4];

   multicycle_core dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .seg_display(seg_display), .retire(retire), .halted(halted)
   );

   multicycle_core #(.REG_COUNT(4)) dut4 (
      .clk(clk), .reset(reset), .imem_addr(imem_addr4), .imem_data(imem_data4),
      .seg_display(seg4), .retire(retire4), .halted(halted4)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt,
                                       input logic [15:0] imm);
      return {op, rd, rs, rt, imm};
   endfunction

   task automatic clear_prog;
      for (int i = 0; i < 64; i++) prog[i] = HALT_I;
   endtask

   // Called at a falling edge; returns at the falling edge inside the first FETCH cycle.
   task automatic do_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Cycle 1 is the first FETCH. Records the cycle of each retire and the display one cycle later.
   task automatic run(input int n_ret, input int max_cyc);
      int cyc;
      bit pend;
      rc.delete(); sq.delete(); sq4.delete();
      cyc  = 1;
      pend = 0;
      while (cyc <= max_cyc) begin
         if (pend) begin
            sq.push_back(seg_display);
            sq4.push_back(seg4);
            pend = 0;
            if (rc.size() >= n_ret) break;
         end
         if (halted) break;
         if (retire) begin
            rc.push_back(cyc);
            pend = 1;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   function automatic logic [31:0] qget(input int idx);
      return (idx < sq.size()) ? sq[idx] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] qget4(input int idx);
      return (idx < sq4.size()) ? sq4[idx] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] cget(input int idx);
      return (idx < rc.size()) ? 32'(rc[idx]) : 32'hFFFF_FFFF;
   endfunction

   initial begin
      int extra;
      reset = 1'b1;
      clear_prog();
      @(negedge clk);

      // Reset state and ADD latency
      prog[0] = ins(4'd0, 4'd3, 4'd1, 4'd2, 16'h0);
      do_reset();
      check_eq("rst_addr", 32'(imem_addr), 32'd0);
      check_eq("rst_seg", seg_display, 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_retire", 32'(retire), 32'd0);
      run(1, 20);
      check_eq("add_retire_cyc", cget(0), 32'd4);
      check_eq("add_seg", qget(0), 32'd0);

      // ALU sequence
      clear_prog();
      prog[0] = ins(4'd5, 4'd1, 4'd0, 4'd0, 16'd5);
      prog[1] = ins(4'd5, 4'd2, 4'd0, 4'd0, 16'hFFFD);
      prog[2] = ins(4'd0, 4'd3, 4'd1, 4'd2, 16'h0);
      prog[3] = ins(4'd1, 4'd4, 4'd2, 4'd1, 16'h0);
      do_reset();
      run(4, 40);
      check_eq("alu_addi5", qget(0), 32'd5);
      check_eq("alu_addim3", qget(1), 32'hFFFF_FFFD);
      check_eq("alu_add", qget(2), 32'd2);
      check_eq("alu_sub", qget(3), 32'hFFFF_FFF8);
      check_eq("alu_last_cyc", cget(3), 32'd16);

      // Memory: address 130 wraps to 2
      clear_prog();
      prog[0] = ins(4'd5, 4'd1, 4'd0, 4'd0, 16'h1234);
      prog[1] = ins(4'd7, 4'd0, 4'd0, 4'd1, 16'd130);
      prog[2] = ins(4'd5, 4'd2, 4'd0, 4'd0, 16'h0055);
      prog[3] = ins(4'd6, 4'd5, 4'd0, 4'd0, 16'd2);
      prog[4] = ins(4'd0, 4'd6, 4'd5, 4'd0, 16'h0);
      do_reset();
      run(5, 60);
      check_eq("mem_sw_cyc", cget(1), 32'd8);
      check_eq("mem_sw_seg", qget(1), 32'h1234);
      check_eq("mem_addi_seg", qget(2), 32'h0055);
      check_eq("mem_lw_seg", qget(3), 32'h1234);
      check_eq("mem_lw_cyc", cget(3), 32'd17);
      check_eq("mem_r5_seg", qget(4), 32'h1234);

      // Branch skips the ADDI r1,7 when enabled
      clear_prog();
      prog[0] = ins(4'd8, 4'd0, 4'd0, 4'd0, 16'd1);
      prog[1] = ins(4'd5, 4'd1, 4'd0, 4'd0, 16'd7);
      prog[2] = ins(4'd5, 4'd1, 4'd0, 4'd0, 16'd9);
      prog[3] = HALT_I;
      do_reset();
      run(99, 60);
      check_eq("br_beq_cyc", cget(0), 32'd3);
`ifdef MULTICYCLE_CORE_BRANCH_EN
      check_eq("br_n_retire", 32'(rc.size()), 32'd3);
      check_eq("br_seg_a", qget(1), 32'd9);
      check_eq("br_halt_cyc", cget(2), 32'd10);
`else
      check_eq("br_n_retire", 32'(rc.size()), 32'd4);
      check_eq("br_seg_a", qget(1), 32'd7);
      check_eq("br_seg_b", qget(2), 32'd9);
      check_eq("br_halt_cyc", cget(3), 32'd14);
`endif
      check_eq("br_halted", 32'(halted), 32'd1);
      check_eq("br_addr", 32'(imem_addr), 32'd4);
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (retire) extra++;
      end
      check_eq("halt_addr_frozen", 32'(imem_addr), 32'd4);
      check_eq("halt_no_retire", 32'(extra), 32'd0);
      check_eq("halt_still", 32'(halted), 32'd1);
      check_eq("halt_seg", seg_display, 32'd9);

      // Writes to r0 and to unimplemented registers
      clear_prog();
      prog[0] = ins(4'd5, 4'd0, 4'd0, 4'd0, 16'd6);
      prog[1] = ins(4'd0, 4'd1, 4'd0, 4'd0, 16'h0);
      prog[2] = ins(4'd5, 4'd9, 4'd0, 4'd0, 16'd3);
      prog[3] = ins(4'd0, 4'd1, 4'd9, 4'd0, 16'h0);
      do_reset();
      run(4, 40);
      check_eq("r0_seg", qget(0), 32'd6);
      check_eq("r0_reads0", qget(1), 32'd0);
      check_eq("r9_full", qget(3), 32'd3);
      check_eq("rc4_r9_seg", qget4(2), 32'd3);
      check_eq("rc4_r9_dropped", qget4(3), 32'd0);

      // Reset during the WB cycle of ADDI r1,r0,8
      clear_prog();
      prog[0] = ins(4'd5, 4'd1, 4'd0, 4'd0, 16'd8);
      do_reset();
      repeat (3) @(negedge clk);
      check_eq("mid_wb_retire", 32'(retire), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("mid_seg", seg_display, 32'd0);
      check_eq("mid_addr", 32'(imem_addr), 32'd0);
      check_eq("mid_halted", 32'(halted), 32'd0);
      prog[0] = ins(4'd0, 4'd2, 4'd1, 4'd0, 16'h0);
      reset = 1'b0;
      run(1, 20);
      check_eq("mid_restart_cyc", cget(0), 32'd4);
      check_eq("mid_r1_zero", qget(0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multicycle successor to the single-cycle processor top. It fetches one 32-bit instruction at a time from an external instruction port. The instruction then steps through a FETCH/DECODE/EXEC/MEM/WB state machine that shares one ALU and an internal register file and data memory. Data width, register count, program-address width and data-memory depth are configurable. The last written-back value drives the seven-segment display bus.

## Interface
- DATA_W, 32: datapath, register and data-memory word width (≥16).
- ADDR_W, 6: PC / instruction-address width.
- REG_COUNT, 16: implemented registers (2..16). r0 reads 0 and is never written.
- DMEM_DEPTH, 128: data-memory words, power of two.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; takes priority over all other activity.
- imem_addr  output  ADDR_W  current PC, driven directly from the PC register.
- imem_data  input  32  instruction word; combinational response to imem_addr, sampled in FETCH.
- seg_display  output  DATA_W  value of the most recent register write-back.
- retire  output  1  one-cycle pulse in the final cycle of each completed instruction.
- halted  output  1  high while in HALT.

## Operation
- Instruction fields: op[31:28], rd[27:24], rs[23:20], rt[19:16], imm[15:0]. imm is sign-extended to DATA_W.
- Opcodes:
  - 0 ADD: rd = rs+rt.
  - 1 SUB: rd = rs−rt.
  - 2 AND, 3 OR, 4 XOR: bitwise, rd = rs op rt.
  - 5 ADDI: rd = rs+imm.
  - 6 LW: rd = dmem[rs+imm].
  - 7 SW: dmem[rs+imm] = rt.
  - 8 BEQ: if rs==rt, pc = pc+1+imm.
  - 9 HALT.
  - 10–15: NOP.
- Arithmetic is modulo 2^DATA_W; carry and overflow are discarded.
- Effective data address uses the low log2(DMEM_DEPTH) bits of the sum, so it wraps. The PC wraps modulo 2^ADDR_W.
- Register indices ≥REG_COUNT read 0 and writes to them are dropped. A write to r0 is dropped, but seg_display still updates with the value.
- State machine:
  - FETCH: latch imem_data into IR; pc <= pc+1.
  - DECODE: latch A = R[rs] and B = R[rt].
  - EXEC: compute ALU result or effective address into ALUOut. BEQ loads pc here when taken. Next state is WB for ALU ops, MEM for LW/SW, FETCH for BEQ/NOP, HALT for HALT.
  - MEM: SW writes dmem and returns to FETCH. LW latches MDR and goes to WB.
  - WB: R[rd] and seg_display <= ALUOut (or MDR for LW); return to FETCH.
  - HALT: terminal state, left only by reset.
- Reset values: pc 0, state FETCH, all registers 0, all dmem words 0, seg_display 0, retire 0, halted 0.

## Timing
- Cycles per instruction:
  - ALU/ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ (taken or not) and NOP: 3.
  - HALT: 3 to reach HALT.
- retire pulses in the last cycle of each instruction: the WB, MEM(SW) or EXEC(BEQ/NOP) cycle. It also pulses in the EXEC cycle of HALT, once only.
- The register write and seg_display update occur on the edge that ends the WB cycle. The next instruction's DECODE sees the new value, so no hazards exist.
- imem_data must be stable in the FETCH cycle only. It is ignored in every other state.
- A taken BEQ offset is relative to the already-incremented PC. Offset −1 loops on itself.
- Reset asserted in any state: on that edge no register or dmem write occurs, and all state returns to reset values. The first FETCH is the cycle after reset deasserts.

## Configuration
- MULTICYCLE_CORE_BRANCH_EN defined: opcode 8 executes BEQ as specified.
- Not defined: opcode 8 is a 3-cycle NOP, the PC is never redirected, and the comparator logic is omitted.

## Test plan
- Reset check: hold reset 2 cycles, then release. Expected: imem_addr 0, seg_display 0, halted 0; first retire exactly 4 cycles after release for an ADD.
- ALU sequence:
  - Program ADDI r1,r0,5; ADDI r2,r0,−3; ADD r3,r1,r2; SUB r4,r2,r1.
  - Expected seg_display sequence: 5, 0xFFFFFFFD, 2, 0xFFFFFFF8. The bench counts 16 cycles from the first FETCH to the last retire.
- Memory:
  - Program ADDI r1,r0,0x1234; SW r1,130(r0); LW r5,2(r0).
  - Expected: with DMEM_DEPTH 128, address 130 wraps to 2, so r5 = seg_display = 0x1234. The LW takes 5 cycles.
- Branch:
  - Program BEQ r0,r0,+1; ADDI r1,r0,7; ADDI r1,r0,9; HALT.
  - Expected: seg_display 9, never 7. halted rises and imem_addr freezes.
  - Rebuild without MULTICYCLE_CORE_BRANCH_EN: the same program shows 7 then 9.
- Edge writes:
  - ADDI r0,r0,6: seg_display 6, but a later ADD r1,r0,r0 gives 0.
  - With REG_COUNT=4, ADDI r9,r0,3 followed by ADD r1,r9,r0 gives 0.
- Reset mid-operation: assert reset during the WB cycle of ADDI r1,r0,8. Expected: r1 stays 0, seg_display 0, and execution restarts at PC 0.
